repl_packer: RTL and testbench

REPL_PACKER -- requirements
Module: repl_packer

---
 rtl/repl_packer_pkg.sv | 26 ++
 rtl/repl_packer_oreg.sv | 37 +++
 rtl/repl_packer.sv | 155 +++++++++++++++
 tb/tb_repl_packer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/repl_packer_pkg.sv
// Shared types and width helpers for the bit-replicating packer.
package repl_packer_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_t;

    localparam int DEF_IN_WIDTH   = 32;
    localparam int DEF_OUT_WIDTH  = 64;
    localparam int DEF_NUM_FIELDS = 4;
    localparam int DEF_MAX_REP    = 16;

    function automatic int rep_w(input int max_rep);
        return $clog2(max_rep + 1);
    endfunction

    function automatic int fill_w(input int out_width);
        return $clog2(out_width + 1);
    endfunction

    function automatic int idx_w(input int in_width);
        return (in_width > 1) ? $clog2(in_width) : 1;
    endfunction

endpackage

// File: rtl/repl_packer_oreg.sv
// Single-entry output holding register with valid/ready handshake.
module repl_packer_oreg
    import repl_packer_pkg::*;
#(
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    localparam int FW = fill_w(OUT_WIDTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load,
    input  logic [OUT_WIDTH-1:0] i_data,
    input  logic [FW-1:0]        i_fill,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [OUT_WIDTH-1:0] o_data,
    output logic [FW-1:0]        o_fill,
    output logic                 o_free
);

    // Free when empty or being drained this cycle, so loads never bubble.
    assign o_free = !o_valid || i_ready;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_fill  <= '0;
        end else if (i_load && o_free) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
            o_fill  <= i_fill;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/repl_packer.sv
// Replicates selected source bits into fields and packs them into
// fixed-width output words, with flush of partial words.
module repl_packer
    import repl_packer_pkg::*;
#(
    parameter int IN_WIDTH   = DEF_IN_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int NUM_FIELDS = DEF_NUM_FIELDS,
    parameter int MAX_REP    = DEF_MAX_REP,
    localparam int IW    = idx_w(IN_WIDTH),
    localparam int REP_W = rep_w(MAX_REP),
    localparam int FW    = fill_w(OUT_WIDTH)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_valid,
    output logic                        o_ready,
    input  logic [IN_WIDTH-1:0]         i_data,
    input  logic [NUM_FIELDS*IW-1:0]    i_cfg_idx,
    input  logic [NUM_FIELDS*REP_W-1:0] i_cfg_rep,
    input  logic                        i_flush,
    output logic                        o_valid,
    input  logic                        i_ready,
    output logic [OUT_WIDTH-1:0]        o_data,
    output logic [FW-1:0]               o_fill,
    output logic                        o_busy
);

    localparam int KW = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam logic [FW:0] OUT_FULL = (FW+1)'(OUT_WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(NUM_FIELDS - 1);

    state_t                      state;
    logic [KW-1:0]               k;
    logic [IN_WIDTH-1:0]         data_q;
    logic [NUM_FIELDS*IW-1:0]    idx_q;
    logic [NUM_FIELDS*REP_W-1:0] rep_q;
    logic [OUT_WIDTH-1:0]        acc;
    logic [FW-1:0]               fill;
    logic                        pend;

    logic [IW-1:0]          cur_idx;
    logic [REP_W-1:0]       cur_rep;
    logic                   cur_bit;
    logic [OUT_WIDTH-1:0]   field;
    logic [2*OUT_WIDTH-1:0] ext;
    logic [FW:0]            sum;

    logic                 complete;
    logic                 oreg_free;
    logic                 flush_req;
    logic                 can_flush;
    logic                 accept;
    logic                 stall;
    logic                 app;
    logic                 ld;
    logic [OUT_WIDTH-1:0] ld_data;
    logic [FW-1:0]        ld_fill;

    // Accumulator bits above fill are kept zero, so appends are a plain OR.
    always_comb begin
        cur_idx = idx_q[int'(k)*IW +: IW];
        cur_rep = rep_q[int'(k)*REP_W +: REP_W];
        cur_bit = data_q[cur_idx];
        field   = '0;
        for (int i = 0; i < OUT_WIDTH; i++) begin
            field[i] = cur_bit && (i < int'(cur_rep));
        end
        ext = {{OUT_WIDTH{1'b0}}, acc}
            | ({{OUT_WIDTH{1'b0}}, field} << fill);
        sum = (FW+1)'(fill) + (FW+1)'(cur_rep);
    end

    assign complete  = (sum >= OUT_FULL);
    assign flush_req = i_flush || pend;
    assign can_flush = (state == IDLE) && flush_req
                    && (fill != '0) && oreg_free;
    // A live flush with data outranks a new source word.
    assign o_ready   = (state == IDLE) && !(flush_req && (fill != '0));
    assign accept    = i_valid && o_ready;
    assign stall     = (state == EXPAND) && complete && !oreg_free;
    assign app       = (state == EXPAND) && !stall;
    assign ld        = can_flush || (app && complete);
    assign ld_data   = can_flush ? acc : ext[OUT_WIDTH-1:0];
    assign ld_fill   = can_flush ? fill : FW'(OUT_WIDTH);
    assign o_busy    = (state != IDLE) || (fill != '0);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            k      <= '0;
            data_q <= '0;
            idx_q  <= '0;
            rep_q  <= '0;
            acc    <= '0;
            fill   <= '0;
            pend   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (flush_req) begin
                        pend <= (fill != '0) && !oreg_free;
                    end
                    if (can_flush) begin
                        acc  <= '0;
                        fill <= '0;
                    end
                    if (accept) begin
                        state  <= EXPAND;
                        k      <= '0;
                        data_q <= i_data;
                        idx_q  <= i_cfg_idx;
                        rep_q  <= i_cfg_rep;
                    end
                end
                EXPAND: begin
                    if (i_flush) begin
                        pend <= 1'b1;
                    end
                    if (app) begin
                        if (complete) begin
                            acc  <= ext[2*OUT_WIDTH-1:OUT_WIDTH];
                            fill <= FW'(sum - OUT_FULL);
                        end else begin
                            acc  <= ext[OUT_WIDTH-1:0];
                            fill <= sum[FW-1:0];
                        end
                        if (k == K_LAST) begin
                            state <= IDLE;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    repl_packer_oreg #(
        .OUT_WIDTH(OUT_WIDTH)
    ) u_oreg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  (ld),
        .i_data  (ld_data),
        .i_fill  (ld_fill),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_fill  (o_fill),
        .o_free  (oreg_free)
    );

endmodule

// File: tb/tb_repl_packer.sv
// Directed and randomized scoreboard bench for repl_packer.
module tb_repl_packer;

    typedef struct packed {
        logic [63:0] d;
        logic [6:0]  f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_data = '0;
    logic [19:0] i_cfg_idx = '0;
    logic [19:0] i_cfg_rep = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [63:0] o_data;
    logic [6:0]  o_fill;
    logic        o_busy;

    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t e;
    logic hold_low = 1'b0;
    logic rand_rdy = 1'b0;
    logic mon_armed = 1'b0;
    logic [63:0] last_d;
    logic [6:0]  last_f;
    logic [63:0] m_acc;
    int          m_fill;

    repl_packer dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .i_cfg_idx (i_cfg_idx),
        .i_cfg_rep (i_cfg_rep),
        .i_flush   (i_flush),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_fill    (o_fill),
        .o_busy    (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        i_ready = hold_low ? 1'b0 :
                  (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
    end

    // Output side: stability while stalled, scoreboard pop on handshake.
    always @(negedge clk) begin
        if (!rst_n || !o_valid) begin
            mon_armed = 1'b0;
        end else begin
            if (mon_armed) begin
                checks++;
                assert (o_data === last_d && o_fill === last_f) else begin
                    errors++;
                    $error("FAIL hold_stable observed=%h/%0d expected=%h/%0d",
                           o_data, o_fill, last_d, last_f);
                end
            end
            if (i_ready) begin
                checks++;
                assert (q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_out observed=%h/%0d expected=none",
                           o_data, o_fill);
                end
                if (q.size() != 0) begin
                    e = q.pop_front();
                    checks++;
                    assert (o_data === e.d && o_fill === e.f) else begin
                        errors++;
                        $error("FAIL out_word observed=%h/%0d expected=%h/%0d",
                               o_data, o_fill, e.d, e.f);
                    end
                end
                mon_armed = 1'b0;
            end else begin
                mon_armed = 1'b1;
                last_d = o_data;
                last_f = o_fill;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] pk(input int f0, input int f1,
                                       input int f2, input int f3);
        return {5'(f3), 5'(f2), 5'(f1), 5'(f0)};
    endfunction

    task automatic send(input logic [31:0] d, input logic [19:0] ix,
                        input logic [19:0] rp);
        logic got;
        got = 1'b0;
        i_valid = 1'b1;
        i_data = d;
        i_cfg_idx = ix;
        i_cfg_rep = rp;
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            got = o_ready;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        chk("accept", 64'(got), 64'd1);
    endtask

    task automatic flush_pulse();
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < 2000 && !ok; n++) begin
            @(negedge clk);
            ok = !o_busy && !o_valid && (q.size() == 0);
            @(posedge clk);
            #1;
        end
        chk(tag, 64'(ok), 64'd1);
    endtask

    task automatic m_word(input logic [31:0] d, input logic [19:0] ix,
                          input logic [19:0] rp);
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < int'(rp[k*5 +: 5]); r++) begin
                m_acc[m_fill] = d[ix[k*5 +: 5]];
                m_fill++;
                if (m_fill == 64) begin
                    q.push_back(exp_t'{m_acc, 7'd64});
                    m_acc = '0;
                    m_fill = 0;
                end
            end
        end
    endtask

    task automatic m_flush();
        if (m_fill > 0) begin
            q.push_back(exp_t'{m_acc, 7'(m_fill)});
        end
        m_acc = '0;
        m_fill = 0;
    endtask

    initial begin
        int cyc;
        logic [31:0] rd;
        logic [19:0] rix;
        logic [19:0] rrp;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(o_valid), 64'd0);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_data", o_data, 64'd0);
        chk("rst_fill", 64'(o_fill), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // All-ones word and its latency from accept
        q.push_back(exp_t'{64'hFFFF_FFFF_FFFF_FFFF, 7'd64});
        i_valid = 1'b1;
        i_data = 32'hFFFF_FFFF;
        i_cfg_idx = pk(0, 0, 0, 0);
        i_cfg_rep = pk(16, 16, 16, 16);
        @(negedge clk);
        chk("lat_ready", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        cyc = 1;
        @(negedge clk);
        while (!o_valid && cyc < 20) begin
            cyc++;
            @(negedge clk);
        end
        chk("lat_cycles", 64'(cyc), 64'd5);
        @(posedge clk);
        #1;
        wait_done("lat_done");

        // Alternating fields, flushed while still expanding
        q.push_back(exp_t'{64'h0F0F, 7'd16});
        send(32'h2, pk(1, 0, 1, 0), pk(4, 4, 4, 4));
        flush_pulse();
        wait_done("alt_done");

        // Word spanning two sources plus a partial tail
        q.push_back(exp_t'{64'hFFFF_FFFF_FFFF_FFFF, 7'd64});
        q.push_back(exp_t'{64'h0000_FFFF_FFFF_FFFF, 7'd48});
        send(32'h1, pk(0, 0, 0, 0), pk(16, 16, 16, 8));
        send(32'h1, pk(0, 0, 0, 0), pk(16, 16, 16, 8));
        flush_pulse();
        wait_done("span_done");

        // Same with the consumer blocked for 10 cycles
        hold_low = 1'b1;
        q.push_back(exp_t'{64'hFFFF_FFFF_FFFF_FFFF, 7'd64});
        q.push_back(exp_t'{64'h0000_FFFF_FFFF_FFFF, 7'd48});
        send(32'h1, pk(0, 0, 0, 0), pk(16, 16, 16, 8));
        send(32'h1, pk(0, 0, 0, 0), pk(16, 16, 16, 8));
        flush_pulse();
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        chk("blk_valid", 64'(o_valid), 64'd1);
        chk("blk_pending", 64'(o_busy), 64'd1);
        @(posedge clk);
        #1;
        hold_low = 1'b0;
        wait_done("blk_done");

        // Second completing word must stall EXPAND while blocked
        hold_low = 1'b1;
        q.push_back(exp_t'{64'hFFFF_FFFF_FFFF_FFFF, 7'd64});
        q.push_back(exp_t'{64'h0000_FFFF_0000_FFFF, 7'd64});
        send(32'h1, pk(0, 0, 0, 0), pk(16, 16, 16, 16));
        send(32'hA, pk(1, 0, 3, 2), pk(16, 16, 16, 16));
        repeat (10) @(posedge clk);
        #1;
        @(negedge clk);
        chk("stall_busy", 64'(o_busy), 64'd1);
        chk("stall_ready", 64'(o_ready), 64'd0);
        @(posedge clk);
        #1;
        hold_low = 1'b0;
        wait_done("stall_done");

        // All-zero replication counts
        send(32'hFFFF_FFFF, pk(0, 1, 2, 3), pk(0, 0, 0, 0));
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("rep0_busy_t4", 64'(o_busy), 64'd1);
        @(negedge clk);
        chk("rep0_busy_t5", 64'(o_busy), 64'd0);
        chk("rep0_ready_t5", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
        flush_pulse();
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rep0_novalid", 64'(o_valid), 64'd0);
        @(posedge clk);
        #1;

        // Reset in the middle of EXPAND
        send(32'hFFFF_FFFF, pk(0, 0, 0, 0), pk(16, 16, 16, 16));
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_valid", 64'(o_valid), 64'd0);
        chk("mrst_ready", 64'(o_ready), 64'd1);
        chk("mrst_busy", 64'(o_busy), 64'd0);
        @(posedge clk);
        #1;
        flush_pulse();
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        chk("mrst_noflush", 64'(o_valid), 64'd0);
        @(posedge clk);
        #1;

        // Random words, random consumer, occasional flushes
        m_acc = '0;
        m_fill = 0;
        rand_rdy = 1'b1;
        for (int w = 0; w < 12; w++) begin
            rd = $urandom;
            for (int k = 0; k < 4; k++) begin
                rix[k*5 +: 5] = 5'($urandom_range(0, 31));
                rrp[k*5 +: 5] = 5'($urandom_range(0, 16));
            end
            m_word(rd, rix, rrp);
            send(rd, rix, rrp);
            if (w % 4 == 3) begin
                m_flush();
                flush_pulse();
            end
        end
        m_flush();
        flush_pulse();
        wait_done("rand_done");
        rand_rdy = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
